// File: rtl/pc_unit_if.sv
// Bundles the fetch-side control inputs and PC / return-stack status outputs of pc_unit.
// The master drives the selects and targets, and the slave (pc_unit) returns the PC state.
interface pc_unit_if #(
  parameter int unsigned W = 32
);
  logic         EN;
  logic [1:0]   S_MXPC;
  logic         PUSH;
  logic [W-1:0] in_ALU;
  logic [W-1:0] in_ADD;
  logic [W-1:0] out;
  logic [W-1:0] out_seq;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_err;

  modport master (
    output EN, S_MXPC, PUSH, in_ALU, in_ADD,
    input  out, out_seq, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  EN, S_MXPC, PUSH, in_ALU, in_ADD,
    output out, out_seq, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// This is a registered program counter. It selects the next PC from the sequential
// address, the ALU target, the adder target or a return-address stack (RAS) pop.
// The RAS is a circular buffer, so a push into a full stack overwrites the oldest entry.
module pc_unit #(
  parameter int unsigned  W         = 32,
  parameter int unsigned  INC       = 1,
  parameter int unsigned  DEPTH     = 4,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter int unsigned  ALIGN     = 0
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);

  localparam int unsigned      PTR_W      = $clog2(DEPTH);
  localparam int unsigned      CNT_W      = $clog2(DEPTH + 1);
  localparam logic [W-1:0]     INC_V      = W'(INC);
  localparam logic [W-1:0]     ALIGN_MASK = {W{1'b1}} << ALIGN;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_ALU = 2'b01,
    SEL_ADD = 2'b10,
    SEL_RAS = 2'b11
  } sel_e;

  logic [W-1:0]     pc_q;
  logic [PTR_W-1:0] ptr_q;   // index of the current top entry
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [W-1:0]     mem [DEPTH];

  sel_e             sel;
  logic [W-1:0]     seq_pc;
  logic [W-1:0]     next_pc;
  logic [PTR_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             empty;
  logic             full;

  assign sel    = sel_e'(bus.S_MXPC);
  assign seq_pc = pc_q + INC_V;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_pc = seq_pc;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;

    unique case (sel)
      SEL_SEQ: next_pc = seq_pc;
      SEL_ALU: next_pc = bus.in_ALU & ALIGN_MASK;
      SEL_ADD: next_pc = bus.in_ADD & ALIGN_MASK;
      SEL_RAS: next_pc = empty ? RESET_VEC : mem[ptr_q];
      default: next_pc = seq_pc;
    endcase

    if (sel == SEL_RAS && !empty && bus.PUSH) begin
      // A call and a return in the same cycle swap the top in place.
      wr_en = 1'b1;
    end else if (sel == SEL_RAS && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else if (bus.PUSH) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_W'(1);
      ptr_d  = wr_idx;
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end

    if (sel == SEL_RAS && empty) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (bus.EN) begin
      pc_q  <= next_pc;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // NOTE: stack storage has no reset. The count alone decides validity, so reset only needs to clear the count.
  always_ff @(posedge clk) begin
    if (!rst && bus.EN && wr_en) mem[wr_idx] <= seq_pc;
  end

  assign bus.out       = pc_q;
  assign bus.out_seq   = seq_pc;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// This is the self-checking bench for pc_unit with W=32, INC=1, DEPTH=4, RESET_VEC=0 and ALIGN=0.
// It applies a vector table, then hand-written return-stack sequences, then random traffic checked against a queue model.
module tb_pc_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_unit_if #(.W(32)) bus ();

  pc_unit #(
    .W(32), .INC(1), .DEPTH(DEPTH), .RESET_VEC(RVEC), .ALIGN(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: the stack is a queue whose back is the most recent call.
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_q [$];

  task automatic model_step(input logic r, input logic e, input logic [1:0] s,
                            input logic p, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] seq;
    logic [31:0] nxt;
    if (r) begin
      m_pc = RVEC;
      m_err = 1'b0;
      m_q.delete();
    end else if (e) begin
      seq = m_pc + 32'd1;
      nxt = seq;
      case (s)
        2'd1: nxt = a;
        2'd2: nxt = d;
        default: nxt = seq;
      endcase
      if (s == 2'd3) begin
        if (m_q.size() == 0) begin
          nxt = RVEC;
          m_err = 1'b1;
          if (p) m_q.push_back(seq);
        end else begin
          nxt = m_q[m_q.size()-1];
          if (p) m_q[m_q.size()-1] = seq;
          else void'(m_q.pop_back());
        end
      end else if (p) begin
        if (m_q.size() == DEPTH) void'(m_q.pop_front());
        m_q.push_back(seq);
      end
      m_pc = nxt;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [1:0] s,
                       input logic p, input logic [31:0] a, input logic [31:0] d);
    rst = r;
    bus.EN = e;
    bus.S_MXPC = s;
    bus.PUSH = p;
    bus.in_ALU = a;
    bus.in_ADD = d;
    model_step(r, e, s, p, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_out,
                              input logic e_empty, input logic e_full, input logic e_err);
    logic [31:0] e_seq;
    e_seq = e_out + 32'd1;
    check({tag, " out"}, bus.out, e_out);
    check({tag, " out_seq"}, bus.out_seq, e_seq);
    check({tag, " ras_empty"}, {31'd0, bus.ras_empty}, {31'd0, e_empty});
    check({tag, " ras_full"}, {31'd0, bus.ras_full}, {31'd0, e_full});
    check({tag, " ras_err"}, {31'd0, bus.ras_err}, {31'd0, e_err});
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic        push;
    logic [31:0] alu;
    logic [31:0] add;
    logic [31:0] e_out;
    logic        e_empty;
    logic        e_full;
    logic        e_err;
  } vec_t;

  function automatic vec_t row(logic r, logic e, logic [1:0] s, logic p, logic [31:0] a,
                               logic [31:0] d, logic [31:0] o, logic em, logic fu, logic er);
    vec_t v;
    v = '{r, e, s, p, a, d, o, em, fu, er};
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.EN = 1'b0;
    bus.S_MXPC = 2'd0;
    bus.PUSH = 1'b0;
    bus.in_ALU = '0;
    bus.in_ADD = '0;
    m_pc = RVEC;
    m_err = 1'b0;

    //              rst   en    sel   push  alu           add           out           emp   full  err
    tbl.push_back(row(1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'd1,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'd2,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'd3,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF0000, 32'h0,        32'hFFFF0000, 1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b0, 2'd1, 1'b1, 32'd5,        32'h0,        32'h0000FFFF, 1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        32'h0000FFFF, 1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        32'd10,       32'd10,       1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd2, 1'b1, 32'h0,        32'd100,      32'd100,      1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        32'h0,        32'd11,       1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd2, 1'b0, 32'h0,        32'h2FF,      32'h2FF,      1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd2, 1'b1, 32'h0,        32'd20,       32'd20,       1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b1, 32'h0,        32'h0,        32'h300,      1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        32'h0,        32'd21,       1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b1, 32'h0,        32'h0,        32'd1,        1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b1, 32'h0,        32'h0,        32'd2,        1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b1, 32'h0,        32'h0,        32'd3,        1'b0, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b1, 32'h0,        32'h0,        32'd4,        1'b0, 1'b1, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b1, 32'h0,        32'h0,        32'd4,        1'b0, 1'b1, 1'b0));
    tbl.push_back(row(1'b1, 1'b0, 2'd3, 1'b1, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b1, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1));
    tbl.push_back(row(1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        32'h0,        32'd1,        1'b1, 1'b0, 1'b1));
    tbl.push_back(row(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'd2,        1'b1, 1'b0, 1'b1));
    tbl.push_back(row(1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].push, tbl[i].alu, tbl[i].add);
      expect_state($sformatf("vec%0d", i), tbl[i].e_out, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_err);
    end

    // Five calls into a four-entry stack: A1 is overwritten, and the pops return A5..A2.
    for (int k = 1; k <= 5; k++) begin
      apply(1'b0, 1'b1, 2'd2, 1'b1, 32'h0, 32'(k) << 8);
    end
    expect_state("calls5", 32'h500, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("pop_a5", 32'h401, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("pop_a4", 32'h301, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("pop_a3", 32'h201, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("pop_a2", 32'h101, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("underflow", 32'h0, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0);
    expect_state("err_sticky", 32'h1, 1'b0, 1'b0, 1'b1);

    // A reset that coincides with a pending pop discards everything.
    apply(1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
    expect_state("rst_pop", 32'h0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        e;
      logic [1:0]  s;
      logic        p;
      logic [31:0] a;
      logic [31:0] d;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      p = ($urandom_range(0, 1) == 1);
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
      apply(r, e, s, p, a, d);
      check($sformatf("rnd%0d out", n), bus.out, m_pc);
      check($sformatf("rnd%0d out_seq", n), bus.out_seq, m_pc + 32'd1);
      check($sformatf("rnd%0d flags", n),
            {29'd0, bus.ras_empty, bus.ras_full, bus.ras_err},
            {29'd0, m_q.size() == 0, m_q.size() == DEPTH, m_err});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
